// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage (ifu_fetch and its FIFO).
package ifu_fetch_pkg;

    localparam int          REG_BUS_WIDTH    = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [REG_BUS_WIDTH-1:0] pc;
        logic [31:0]              inst;
    } fetch_entry_t;

    function automatic logic [REG_BUS_WIDTH-1:0] word_align(input logic [REG_BUS_WIDTH-1:0] a);
        return {a[REG_BUS_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: synchronous FIFO of fetched {pc, inst} entries with push/pop/clear.
// Pop on empty is ignored; the caller guarantees no push while full.
module ifu_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~i_clear;
    assign w_pop   = i_pop & ~i_clear & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage carries data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch-PC generation, pipelined instruction-bus requests and response buffering.
// Optional macro IFU_BYPASS_EN lets a response reach the outputs in its arrival cycle when the FIFO is empty.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall_i,
    input  logic [3:0]               flush_i,
    input  logic [REG_BUS_WIDTH-1:0] jump_addr_i,
    output logic                     ibus_req_o,
    output logic [REG_BUS_WIDTH-1:0] ibus_addr_o,
    input  logic                     ibus_gnt_i,
    input  logic                     ibus_rvalid_i,
    input  logic [31:0]              ibus_rdata_i,
    output logic [REG_BUS_WIDTH-1:0] pc_o,
    output logic [31:0]              inst_o,
    output logic                     stall_req_o
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [REG_BUS_WIDTH-1:0] r_fetch_pc;
    logic [REG_BUS_WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]            r_outstanding;
    logic [CW-1:0]            r_kill;

    logic [CW-1:0]            w_count;
    logic [CW:0]              w_occ;
    logic                     w_empty;
    logic                     w_flush;
    logic                     w_req;
    logic                     w_issue;
    logic                     w_keep;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_pop;
    logic [CW-1:0]            w_out_next;
    logic [REG_BUS_WIDTH-1:0] w_target;
    fetch_entry_t             w_push_entry;
    fetch_entry_t             w_head;
    logic                     w_unused;

    assign w_unused = ^{stall_i[5:2], flush_i[3:1], jump_addr_i[1:0]};

    assign w_flush  = flush_i[0];
    assign w_target = word_align(jump_addr_i);
    assign w_occ    = {1'b0, r_outstanding} + {1'b0, w_count};
    // Request is gated by rst so the bus sees no request while reset is held.
    assign w_req    = ~rst & ~stall_i[0] & ~w_flush & (w_occ < DEPTH_C);
    assign w_issue  = w_req & ibus_gnt_i;
    assign w_keep   = ibus_rvalid_i & (r_kill == '0) & ~w_flush;

`ifdef IFU_BYPASS_EN
    assign w_bypass = w_empty & w_keep;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that is consumed immediately never enters the FIFO.
    assign w_push     = w_keep & ~(w_bypass & ~stall_i[1]);
    assign w_pop      = ~w_empty & ~stall_i[1] & ~w_flush;
    assign w_out_next = r_outstanding + CW'(w_issue) - CW'(ibus_rvalid_i);

    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = ibus_rdata_i;

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_flush),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_flush) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_kill     <= w_out_next;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_keep)  r_resp_pc  <= r_resp_pc + 32'd4;
                if (ibus_rvalid_i && r_kill != '0) r_kill <= r_kill - CW'(1);
            end
        end
    end

    assign ibus_req_o  = w_req;
    assign ibus_addr_o = r_fetch_pc;

    always_comb begin
        pc_o        = r_resp_pc;
        inst_o      = INST_NOP;
        stall_req_o = 1'b1;
        if (w_bypass) begin
            inst_o      = ibus_rdata_i;
            stall_req_o = 1'b0;
        end else if (!w_empty) begin
            pc_o        = w_head.pc;
            inst_o      = w_head.inst;
            stall_req_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, latency sequence, async reset, and a randomized
// bus responder checked against a program-order model of the presented instruction stream.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic [3:0]  flush_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stall_req_o;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .stall_req_o   (stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st0, st1, fl;
        logic [31:0] jmp;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr, e_pc, e_inst;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } pend_t;

    vec_t  tbl[$];
    pend_t pend[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    function automatic vec_t V(input logic st0, st1, fl, input logic [31:0] jmp,
                               input logic gnt, rv, input logic [31:0] rdaddr,
                               input logic e_req, input logic [31:0] e_addr, e_pc, e_inst,
                               input logic e_stall);
        vec_t v;
        v.st0 = st0; v.st1 = st1; v.fl = fl; v.jmp = jmp; v.gnt = gnt; v.rv = rv;
        v.rd = memfn(rdaddr);
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_inst = e_inst; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_i = '0; flush_i = '0; jump_addr_i = '0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_stall);
        chk({tag, ".req"},   32'(ibus_req_o),  32'(e_req));
        chk({tag, ".addr"},  ibus_addr_o,      e_addr);
        chk({tag, ".pc"},    pc_o,             e_pc);
        chk({tag, ".inst"},  inst_o,           e_inst);
        chk({tag, ".stall"}, 32'(stall_req_o), 32'(e_stall));
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] jmp;
        int          consumed;

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk_outs("reset", 1'b0, 32'h0, 32'h0, NOP, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

`ifndef IFU_BYPASS_EN
        //            st0 st1 fl jmp       gnt rv rdaddr     req addr      pc        inst           stall
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h000, 32'h000, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 32'h0,     1, 32'h004, 32'h000, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 32'h4,     0, 32'h008, 32'h000, 32'hA000_0000, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h008, 32'h004, 32'hA000_0004, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 32'h8,     1, 32'h00C, 32'h008, NOP,           1));
        tbl.push_back(V(0, 1, 0, 32'h0,    1, 1, 32'hC,     0, 32'h010, 32'h008, 32'hA000_0008, 0));
        tbl.push_back(V(0, 1, 0, 32'h0,    1, 0, 32'h0,     0, 32'h010, 32'h008, 32'hA000_0008, 0));
        tbl.push_back(V(0, 1, 0, 32'h0,    1, 0, 32'h0,     0, 32'h010, 32'h008, 32'hA000_0008, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     0, 32'h010, 32'h008, 32'hA000_0008, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h010, 32'h00C, 32'hA000_000C, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h010, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h010, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h010, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h010, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h014, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 1, 32'h103,  1, 1, 32'h10,    0, 32'h018, 32'h010, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 32'h14,    1, 32'h100, 32'h100, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h100, 32'h100, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 32'h100,   1, 32'h104, 32'h100, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h104, 32'h100, 32'hA000_0100, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h104, 32'h104, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h108, 32'h104, NOP,           1));
        tbl.push_back(V(0, 0, 1, 32'h200,  1, 0, 32'h0,     0, 32'h10C, 32'h104, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 32'h104,   0, 32'h200, 32'h200, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 32'h108,   1, 32'h200, 32'h200, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 32'h0,     1, 32'h200, 32'h200, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 32'h200,   1, 32'h204, 32'h200, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h204, 32'h200, 32'hA000_0200, 0));
        tbl.push_back(V(1, 0, 0, 32'h0,    1, 0, 32'h0,     0, 32'h204, 32'h204, NOP,           1));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 32'h0,     1, 32'h204, 32'h204, NOP,           1));

        foreach (tbl[i]) begin
            stall_i       = {4'b0, tbl[i].st1, tbl[i].st0};
            flush_i       = {3'b0, tbl[i].fl};
            jump_addr_i   = tbl[i].jmp;
            ibus_gnt_i    = tbl[i].gnt;
            ibus_rvalid_i = tbl[i].rv;
            ibus_rdata_i  = tbl[i].rd;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                     tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_stall);
            @(posedge clk);
            #1;
        end
`endif

        // Response latency through an empty FIFO: bypass presents in the rvalid cycle.
        do_reset();
        ibus_gnt_i = 1'b1;
        @(negedge clk);
        chk("lat.req", 32'(ibus_req_o), 32'h1);
        @(posedge clk);
        #1;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = memfn(32'h0);
        @(negedge clk);
`ifdef IFU_BYPASS_EN
        chk_outs("lat.T", 1'b1, 32'h4, 32'h0, 32'hA000_0000, 1'b0);
`else
        chk_outs("lat.T", 1'b1, 32'h4, 32'h0, NOP, 1'b1);
`endif
        @(posedge clk);
        #1;
        ibus_rvalid_i = 1'b0;
        @(negedge clk);
`ifdef IFU_BYPASS_EN
        chk_outs("lat.T1", 1'b1, 32'h4, 32'h4, NOP, 1'b1);
`else
        chk_outs("lat.T1", 1'b1, 32'h4, 32'h0, 32'hA000_0000, 1'b0);
`endif

        // Asynchronous reset in the middle of a cycle clears state immediately.
        @(posedge clk);
        #1;
        idle_inputs();
        ibus_gnt_i = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 32'h0, 32'h0, NOP, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();

        // Randomized traffic: presented stream must follow program order from the latest redirect.
        pend.delete();
        exp_pc   = 32'h0;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            stall_i     = {4'b0, ($urandom_range(3) == 0), ($urandom_range(7) == 0)};
            flush_i     = {3'b0, ($urandom_range(31) == 0)};
            jmp         = ($urandom_range(3) == 0) ? 32'hFFFF_FFF4 : 32'($urandom);
            jump_addr_i = jmp;
            ibus_gnt_i  = ($urandom_range(3) != 0);
            ibus_rvalid_i = (pend.size() > 0) && (pend[0].rdy <= c) && ($urandom_range(3) != 0);
            ibus_rdata_i  = ibus_rvalid_i ? memfn(pend[0].addr) : 32'($urandom);
            @(negedge clk);
            if (ibus_req_o && ibus_gnt_i) begin
                if (ibus_addr_o[1:0] != 2'b00 || pend.size() >= DEPTH) begin
                    chk("rnd.req_legal", {ibus_addr_o[1:0], 30'(pend.size())}, 32'(DEPTH - 1));
                end
                pend.push_back('{addr: ibus_addr_o, rdy: c + 1 + int'($urandom_range(2))});
            end
            if (ibus_rvalid_i) void'(pend.pop_front());
            if (stall_req_o) begin
                if (inst_o !== NOP) chk("rnd.nop", inst_o, NOP);
            end
            if (flush_i[0]) begin
                exp_pc = {jmp[31:2], 2'b00};
            end else if (!stall_req_o && !stall_i[1]) begin
                chk("rnd.pc", pc_o, exp_pc);
                chk("rnd.inst", inst_o, memfn(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            @(posedge clk);
            #1;
        end
        chk("rnd.progress", 32'(consumed > 300), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
